// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Port 0 is the CPU core and port 1 is the debug loader. Every output is registered.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  err0,
    output logic                  ack1,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_oe,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;

    state_t state;
    logic   last_grant;
    logic   cur_port;

    logic                  pick_valid;
    logic                  pick_port;
    logic                  pick_we;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        pick_valid = req0 | req1;
        pick_port  = (req0 & req1) ? ~last_grant : req1;
        pick_we    = pick_port ? we1    : we0;
        pick_addr  = pick_port ? addr1  : addr0;
        pick_wdata = pick_port ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        last_grant <= pick_port;
                        cur_port   <= pick_port;
                        mem_addr   <= pick_addr;
                        mem_wdata  <= pick_wdata;
                        busy       <= 1'b1;
                        // The top address bit marks an unmapped address. The RAM is never touched for it.
                        if (pick_addr[ADDR_WIDTH-1]) begin
                            state <= DONE;
                            ack0  <= ~pick_port;
                            ack1  <= pick_port;
                            err0  <= ~pick_port;
                            err1  <= pick_port;
                        end else if (pick_we) begin
                            state  <= WR;
                            mem_we <= 1'b1;
                        end else begin
                            state  <= RD_A;
                            mem_oe <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    state <= RD_B;
                end
                RD_B: begin
                    state  <= DONE;
                    mem_oe <= 1'b0;
                    rdata  <= mem_rdata;
                    ack0   <= ~cur_port;
                    ack1   <= cur_port;
                end
                WR: begin
                    state  <= DONE;
                    mem_we <= 1'b0;
                    ack0   <= ~cur_port;
                    ack1   <= cur_port;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_oe <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 256-byte RAM model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        ack0, err0, ack1, err1, mem_oe, mem_we, busy;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    logic [7:0] ram [0:255];

    // Results returned by the access task.
    int          lat, oe_cyc, we_cyc;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic        got_err;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .err0(err0), .ack1(ack1), .err1(err1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    always @(negedge clk) if (mem_oe && mem_we) overlap++;

    // One access from port p. The cycle index k=1 is the first negedge after the grant edge.
    task automatic access(input int p, input logic w, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        lat = 0; oe_cyc = 0; we_cyc = 0; got_err = 0; w_addr = 'x; w_data = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_oe) oe_cyc++;
            if (mem_we) begin we_cyc++; w_addr = mem_addr; w_data = mem_wdata; end
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                lat = k;
                got_err = (p == 0) ? err0 : err1;
                break;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        #2;
        checks++;
        if ({ack0, ack1, err0, err1, mem_oe, mem_we, busy} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=0000000", {ack0, ack1, err0, err1, mem_oe, mem_we, busy});
        end
        checks++;
        if ({rdata, mem_addr, mem_wdata} !== 32'h0) begin
            errors++; $display("FAIL reset_data got=%h want=00000000", {rdata, mem_addr, mem_wdata});
        end
        @(negedge clk); @(negedge clk);
        reset = 0;
    endtask

    task automatic test_write;
        access(0, 1, 16'h0002, 8'h25);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL write_latency got=%0d want=2", lat); end
        checks++;
        if (we_cyc !== 1 || oe_cyc !== 0) begin
            errors++; $display("FAIL write_strobes got we=%0d oe=%0d want we=1 oe=0", we_cyc, oe_cyc);
        end
        checks++;
        if (w_addr !== 16'h0002 || w_data !== 8'h25) begin
            errors++; $display("FAIL write_bus got addr=%h data=%h want addr=0002 data=25", w_addr, w_data);
        end
        checks++;
        if (got_err !== 1'b0) begin errors++; $display("FAIL write_err got=%b want=0", got_err); end
    endtask

    task automatic test_read;
        access(1, 0, 16'h0002, 8'h00);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL read_latency got=%0d want=3", lat); end
        checks++;
        if (oe_cyc !== 2 || we_cyc !== 0) begin
            errors++; $display("FAIL read_strobes got oe=%0d we=%0d want oe=2 we=0", oe_cyc, we_cyc);
        end
        checks++;
        if (rdata !== 8'h25) begin errors++; $display("FAIL read_data got=%h want=25", rdata); end
        @(negedge clk);
        checks++;
        if (rdata !== 8'h25 || busy !== 1'b0) begin
            errors++; $display("FAIL read_hold got rdata=%h busy=%b want rdata=25 busy=0", rdata, busy);
        end
    endtask

    task automatic test_error;
        access(0, 0, 16'h8000, 8'h00);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL err_latency got=%0d want=1", lat); end
        checks++;
        if (got_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%b want=1", got_err); end
        checks++;
        if (oe_cyc !== 0 || we_cyc !== 0) begin
            errors++; $display("FAIL err_strobes got oe=%0d we=%0d want 0 0", oe_cyc, we_cyc);
        end
        checks++;
        if (rdata !== 8'h25) begin errors++; $display("FAIL err_rdata got=%h want=25", rdata); end
    endtask

    task automatic test_round_robin;
        int order [4];
        int n;
        logic both;
        reset = 1;
        @(negedge clk);
        reset = 0;
        ram[3] = 8'h5A;
        req0 = 1; we0 = 0; addr0 = 16'h0002;
        req1 = 1; we1 = 0; addr1 = 16'h0003;
        n = 0; both = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1;
            if (ack0) begin order[n] = 0; n++; end
            else if (ack1) begin order[n] = 1; n++; end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL rr_count got=%0d want=4", n); end
        checks++;
        if (n == 4 && (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1)) begin
            errors++; $display("FAIL rr_order got=%0d%0d%0d%0d want=0101", order[0], order[1], order[2], order[3]);
        end
        checks++;
        if (both !== 1'b0) begin errors++; $display("FAIL rr_double_ack got=%b want=0", both); end
        checks++;
        if (rdata !== 8'h5A) begin errors++; $display("FAIL rr_last_rdata got=%h want=5a", rdata); end
        @(negedge clk);
    endtask

    task automatic test_req_drop;
        int k_ack;
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 16'h0002;
        @(negedge clk);
        req1 = 0;
        k_ack = 0;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (ack1) begin k_ack = k; break; end
        end
        checks++;
        if (k_ack !== 3) begin errors++; $display("FAIL drop_ack got=%0d want=3", k_ack); end
        @(negedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid;
        logic seen_ack;
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 16'h0003;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_oe !== 1'b1) begin errors++; $display("FAIL mid_rdb_oe got=%b want=1", mem_oe); end
        reset = 1;
        #1;
        checks++;
        if (mem_oe !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_abort got oe=%b busy=%b want 0 0", mem_oe, busy);
        end
        req0 = 0;
        seen_ack = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) seen_ack = 1;
        end
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack0 || ack1) seen_ack = 1;
        end
        checks++;
        if (seen_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack got=%b want=0", seen_ack); end
        access(0, 0, 16'h0002, 8'h00);
        checks++;
        if (lat !== 3 || rdata !== 8'h25) begin
            errors++; $display("FAIL mid_recover got lat=%0d rdata=%h want lat=3 rdata=25", lat, rdata);
        end
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 256; i++) begin
            access(i % 2, 1, 16'(i), 8'(8'hFF - i));
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL sweep_wr_lat i=%0d got=%0d want=2", i, lat); end
        end
        for (int i = 0; i < 256; i++) begin
            access((i + 1) % 2, 0, 16'(i), 8'h00);
            checks++;
            if (rdata !== 8'(8'hFF - i) || lat !== 3) begin
                errors++; $display("FAIL sweep_rd i=%0d got=%h lat=%0d want=%h lat=3", i, rdata, lat, 8'(8'hFF - i));
            end
        end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL oe_we_overlap got=%0d want=0", overlap); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_error;
        test_round_robin;
        test_req_drop;
        test_reset_mid;
        test_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
